rename_recovery_ctrl: RTL and testbench

//  Multi-cycle sequencer that restores the speculative rename map from the committed map after a branch flush.
//  It copies LANES entries per cycle, then patches entries hit by commits that land mid-walk.
//  It releases all speculative-only physical registers in one mask pulse at the end.
//  It sits beside the register-rename unit and stalls rename for the whole recovery.

---
 rtl/rename_pkg.sv | 10 +
 rtl/rename_dirty_pick.sv | 28 ++
 rtl/rename_recovery_ctrl.sv | 124 ++++++++++++
 tb/tb_rename_recovery_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rename_pkg.sv
// rtl/rename_pkg.sv - shared constants and state encoding for rename-map recovery
package rename_pkg;
  localparam int ARCH_REGS = 32;
  localparam int PHY_REGS  = 64;
  localparam int LANES     = 4;
  localparam int AW        = 5;
  localparam int PW        = 6;

  typedef enum logic [1:0] {IDLE, WALK, FIXUP, RELEASE} state_t;
endpackage

// File: rtl/rename_dirty_pick.sv
// rtl/rename_dirty_pick.sv - picks up to LANES lowest set bits of the dirty vector
module rename_dirty_pick
  import rename_pkg::*;
(
  input  logic [ARCH_REGS-1:0]        dirty,
  output logic [LANES-1:0][AW-1:0]    pick_idx,
  output logic [LANES-1:0]            pick_valid
);

  logic [ARCH_REGS-1:0] rem;

  // Each lane takes the lowest bit still left, then removes it for the next lane.
  always_comb begin
    rem        = dirty;
    pick_idx   = '0;
    pick_valid = '0;
    for (int k = 0; k < LANES; k++) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        if (rem[i] && !pick_valid[k]) begin
          pick_idx[k]   = AW'(i);
          pick_valid[k] = 1'b1;
        end
      end
      if (pick_valid[k]) rem[pick_idx[k]] = 1'b0;
    end
  end

endmodule

// File: rtl/rename_recovery_ctrl.sv
// rtl/rename_recovery_ctrl.sv - restores speculative rename map from committed map after a flush
module rename_recovery_ctrl
  import rename_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_req,
  input  logic                  commit_valid,
  input  logic [AW-1:0]         commit_rdst,
  input  logic [PW-1:0]         commit_phy,
  input  logic [PHY_REGS-1:0]   spec_mask,
  output logic [LANES*AW-1:0]   cmap_rd_idx,
  input  logic [LANES*PW-1:0]   cmap_rd_data,
  output logic [LANES-1:0]      smap_wr_en,
  output logic [LANES*AW-1:0]   smap_wr_idx,
  output logic [LANES*PW-1:0]   smap_wr_data,
  output logic                  free_rel_valid,
  output logic [PHY_REGS-1:0]   free_rel_mask,
  output logic                  rename_stall,
  output logic                  busy
);

  state_t                    state_q, state_d;
  logic [AW-1:0]             cnt_q, cnt_d;
  logic [ARCH_REGS-1:0]      dirty_q, dirty_d;
  logic [PHY_REGS-1:0]       rel_mask_q, rel_mask_d;
  logic [LANES-1:0][AW-1:0]  pick_idx, lane_idx;
  logic [LANES-1:0]          pick_valid, lane_en;
  logic                      commit_hit, sel_hit;

  rename_dirty_pick u_pick (
    .dirty      (dirty_q),
    .pick_idx   (pick_idx),
    .pick_valid (pick_valid)
  );

  assign commit_hit   = commit_valid && (commit_rdst != '0);
  assign rename_stall = flush_req | (state_q != IDLE);
  assign busy         = (state_q != IDLE);

  always_comb begin
    lane_idx = '0;
    lane_en  = '0;
    if (state_q == WALK) begin
      for (int k = 0; k < LANES; k++) begin
        lane_idx[k] = cnt_q + AW'(k);
        lane_en[k]  = (lane_idx[k] != '0);
      end
    end else if (state_q == FIXUP) begin
      lane_idx = pick_idx;
      lane_en  = pick_valid;
    end
  end

  // A commit landing on a lane being written is bypassed into that write.
  always_comb begin
    sel_hit = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      cmap_rd_idx[k*AW +: AW]  = lane_idx[k];
      smap_wr_idx[k*AW +: AW]  = lane_idx[k];
      smap_wr_en[k]            = lane_en[k];
      smap_wr_data[k*PW +: PW] = '0;
      if (lane_en[k]) begin
        smap_wr_data[k*PW +: PW] = (commit_hit && commit_rdst == lane_idx[k]) ?
                                   commit_phy : cmap_rd_data[k*PW +: PW];
        if (commit_hit && commit_rdst == lane_idx[k]) sel_hit = 1'b1;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    dirty_d        = dirty_q;
    rel_mask_d     = rel_mask_q;
    free_rel_valid = 1'b0;
    free_rel_mask  = '0;
    case (state_q)
      WALK: begin
        if (commit_hit && commit_rdst < cnt_q) dirty_d[commit_rdst] = 1'b1;
        cnt_d = cnt_q + AW'(LANES);
        if (cnt_q == AW'(ARCH_REGS - LANES))
          state_d = (dirty_d == '0) ? RELEASE : FIXUP;
      end
      FIXUP: begin
        for (int k = 0; k < LANES; k++)
          if (pick_valid[k]) dirty_d[pick_idx[k]] = 1'b0;
        if (commit_hit && !sel_hit) dirty_d[commit_rdst] = 1'b1;
        if (dirty_d == '0) state_d = RELEASE;
      end
      RELEASE: begin
        free_rel_valid = 1'b1;
        free_rel_mask  = rel_mask_q;
        rel_mask_d     = '0;
        state_d        = IDLE;
      end
      default: ;
    endcase
    // A new flush restarts the walk and folds its mask into any pending release.
    if (flush_req) begin
      state_d        = WALK;
      cnt_d          = '0;
      dirty_d        = '0;
      rel_mask_d     = (state_q == IDLE) ? spec_mask : (rel_mask_q | spec_mask);
      free_rel_valid = 1'b0;
      free_rel_mask  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      dirty_q    <= '0;
      rel_mask_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dirty_q    <= dirty_d;
      rel_mask_q <= rel_mask_d;
    end
  end

endmodule

// File: tb/tb_rename_recovery_ctrl.sv
// tb/tb_rename_recovery_ctrl.sv - scoreboard bench for rename_recovery_ctrl
module tb_rename_recovery_ctrl;
  import rename_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  flush_req = 1'b0;
  logic                  commit_valid = 1'b0;
  logic [AW-1:0]         commit_rdst = '0;
  logic [PW-1:0]         commit_phy = '0;
  logic [PHY_REGS-1:0]   spec_mask = '0;
  logic [LANES*AW-1:0]   cmap_rd_idx;
  logic [LANES*PW-1:0]   cmap_rd_data;
  logic [LANES-1:0]      smap_wr_en;
  logic [LANES*AW-1:0]   smap_wr_idx;
  logic [LANES*PW-1:0]   smap_wr_data;
  logic                  free_rel_valid;
  logic [PHY_REGS-1:0]   free_rel_mask;
  logic                  rename_stall;
  logic                  busy;

  rename_recovery_ctrl dut (
    .clk(clk), .rst_n(rst_n), .flush_req(flush_req),
    .commit_valid(commit_valid), .commit_rdst(commit_rdst), .commit_phy(commit_phy),
    .spec_mask(spec_mask), .cmap_rd_idx(cmap_rd_idx), .cmap_rd_data(cmap_rd_data),
    .smap_wr_en(smap_wr_en), .smap_wr_idx(smap_wr_idx), .smap_wr_data(smap_wr_data),
    .free_rel_valid(free_rel_valid), .free_rel_mask(free_rel_mask),
    .rename_stall(rename_stall), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Committed map model: combinational read, written by commits at the clock edge.
  logic [PW-1:0] cmap [ARCH_REGS];
  logic          cmap_init = 1'b1;
  always @(posedge clk) begin
    if (cmap_init) begin
      for (int i = 0; i < ARCH_REGS; i++) cmap[i] <= PW'(i + 32);
    end else if (commit_valid && commit_rdst != '0) begin
      cmap[commit_rdst] <= commit_phy;
    end
  end
  always_comb begin
    for (int k = 0; k < LANES; k++)
      cmap_rd_data[k*PW +: PW] = cmap[cmap_rd_idx[k*AW +: AW]];
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] pack(input int c, input int idx, input int d);
    return {c[15:0], idx[7:0], d[7:0]};
  endfunction

  logic [31:0] wr_q [$];
  int          rel_cyc_q [$];
  logic [63:0] rel_mask_q [$];
  int          exp_val [ARCH_REGS];

  // Monitor samples mid-cycle, after the bench has driven that cycle's inputs.
  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      check("rst_wr_en", 64'(smap_wr_en), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
    end else begin
      for (int k = 0; k < LANES; k++) begin
        if (smap_wr_en[k]) begin
          logic [31:0] obs;
          obs = pack(cyc, int'(smap_wr_idx[k*AW +: AW]), int'(smap_wr_data[k*PW +: PW]));
          if (wr_q.size() > 0) check("wr", 64'(obs), 64'(wr_q.pop_front()));
          else check("wr_unexp", 64'(obs), 64'd0);
        end
      end
      if (free_rel_valid) begin
        if (rel_cyc_q.size() > 0) begin
          check("rel_cyc", 64'(cyc), 64'(rel_cyc_q.pop_front()));
          check("rel_mask", free_rel_mask, rel_mask_q.pop_front());
        end else begin
          check("rel_unexp", 64'd1, 64'd0);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic reset_model();
    for (int i = 0; i < ARCH_REGS; i++) exp_val[i] = i + 32;
    cmap_init = 1'b1;
    tick();
    cmap_init = 1'b0;
  endtask

  task automatic push_walk(input int t0, input int ncyc);
    for (int c = 1; c <= ncyc; c++)
      for (int k = 0; k < LANES; k++) begin
        int idx;
        idx = LANES * (c - 1) + k;
        if (idx != 0) wr_q.push_back(pack(t0 + c, idx, exp_val[idx]));
      end
  endtask

  task automatic push_rel(input int c, input logic [63:0] m);
    rel_cyc_q.push_back(c);
    rel_mask_q.push_back(m);
  endtask

  task automatic raise_flush(input logic [63:0] m);
    flush_req = 1'b1;
    spec_mask = m;
    #1 check("stall_on_flush", 64'(rename_stall), 64'd1);
  endtask

  task automatic commit_at(input int c, input int rdst, input int phy);
    wait_until(c);
    commit_valid = 1'b1;
    commit_rdst  = AW'(rdst);
    commit_phy   = PW'(phy);
    tick();
    commit_valid = 1'b0;
  endtask

  task automatic check_busy_end(input int rel_c);
    wait_until(rel_c);
    check("busy_at_release", 64'(busy), 64'd1);
    tick();
    check("busy_after_release", 64'(busy), 64'd0);
  endtask

  task automatic drain(input string tag);
    int budget;
    budget = 40;
    while ((wr_q.size() > 0 || rel_cyc_q.size() > 0) && budget > 0) begin
      tick();
      budget--;
    end
    check({tag, "_wr_left"}, 64'(wr_q.size()), 64'd0);
    check({tag, "_rel_left"}, 64'(rel_cyc_q.size()), 64'd0);
    wr_q.delete();
    rel_cyc_q.delete();
    rel_mask_q.delete();
    repeat (2) tick();
  endtask

  initial begin
    int t;
    tick();
    check("rst_rel_valid", 64'(free_rel_valid), 64'd0);
    check("rst_wr_data", 64'(smap_wr_data), 64'd0);
    check("rst_stall_idle", 64'(rename_stall), 64'd0);
    flush_req = 1'b1;
    #1 check("rst_stall_follows_flush", 64'(rename_stall), 64'd1);
    flush_req = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // Plain recovery
    reset_model();
    t = cyc;
    raise_flush(64'hF0);
    push_walk(t, 8);
    push_rel(t + 9, 64'hF0);
    tick();
    flush_req = 1'b0;
    check_busy_end(t + 9);
    drain("plain");

    // Commit inside the current lanes is bypassed
    reset_model();
    t = cyc;
    raise_flush(64'hF0);
    exp_val[6] = 50;
    push_walk(t, 8);
    push_rel(t + 9, 64'hF0);
    tick();
    flush_req = 1'b0;
    commit_at(t + 2, 6, 50);
    check_busy_end(t + 9);
    drain("bypass");

    // Commits behind the walk pointer need one fixup cycle
    reset_model();
    t = cyc;
    raise_flush(64'hF0);
    push_walk(t, 8);
    wr_q.push_back(pack(t + 9, 2, 40));
    wr_q.push_back(pack(t + 9, 3, 41));
    push_rel(t + 10, 64'hF0);
    tick();
    flush_req = 1'b0;
    commit_at(t + 5, 2, 40);
    commit_at(t + 6, 3, 41);
    check_busy_end(t + 10);
    drain("fixup");

    // Second flush mid-walk restarts and merges masks
    reset_model();
    t = cyc;
    raise_flush(64'hF0);
    push_walk(t, 3);
    tick();
    flush_req = 1'b0;
    wait_until(t + 3);
    raise_flush(64'h300);
    push_walk(t + 3, 8);
    push_rel(t + 12, 64'h3F0);
    tick();
    flush_req = 1'b0;
    check_busy_end(t + 12);
    drain("reflush");

    // Commit to register 0 is ignored
    reset_model();
    t = cyc;
    raise_flush(64'h5);
    push_walk(t, 8);
    push_rel(t + 9, 64'h5);
    tick();
    flush_req = 1'b0;
    commit_at(t + 5, 0, 9);
    check_busy_end(t + 9);
    drain("rdst0");

    // Reset in the middle of the walk aborts everything
    reset_model();
    t = cyc;
    raise_flush(64'hF0);
    push_walk(t, 3);
    tick();
    flush_req = 1'b0;
    wait_until(t + 4);
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    repeat (12) tick();
    check("abort_busy", 64'(busy), 64'd0);
    drain("abort");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
